// File: rtl/div_bcd_converter.sv
// Binary-to-BCD converter (shift-and-add-3, one bit per clock) fed by the divider's quotient/remainder.
// Latency: START to DONE is WIDTH+1 clocks. Backpressure: START is taken only in IDLE; START while busy or in the DONE cycle is dropped.
// Optional BLANK output (leading-zero blanking) under macro BCD_BLANK_EN.
module div_bcd_converter #(
  parameter int WIDTH  = 5,
  parameter int DIGITS = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [WIDTH-1:0]      BIN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [4*DIGITS-1:0]   BCD,
  output logic                  OVF
`ifdef BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     BLANK
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FIN   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   dig_q, dig_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic            acc_q, acc_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            ovf_q, ovf_d;
  logic [BW-1:0]   adj;
`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              zero_above;
`endif

  always_comb begin
    adj = dig_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
`ifdef BCD_BLANK_EN
    blank_d    = blank_q;
    zero_above = 1'b1;
`endif
    case (state_q)
      S_IDLE: begin
        if (START) begin
          bin_d   = BIN;
          dig_d   = '0;
          acc_d   = 1'b0;
          cnt_d   = CW'(WIDTH);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // A bit leaving the top digit is a carry into a digit we do not keep.
        dig_d = {adj[BW-2:0], bin_q[WIDTH-1]};
        bin_d = {bin_q[WIDTH-2:0], 1'b0};
        acc_d = acc_q | adj[BW-1];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Result registers load on entry to FIN so they are valid alongside DONE.
          state_d = S_FIN;
          bcd_d   = dig_d;
          ovf_d   = acc_d;
`ifdef BCD_BLANK_EN
          for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (dig_d[4*i +: 4] == 4'd0);
            blank_d[i] = zero_above;
          end
          blank_d[0] = 1'b0;
`endif
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dig_q   <= '0;
      bin_q   <= '0;
      acc_q   <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef BCD_BLANK_EN
      blank_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
`ifdef BCD_BLANK_EN
      blank_q <= blank_d;
`endif
    end
  end

  assign BUSY = (state_q == S_SHIFT);
  assign DONE = (state_q == S_FIN);
  assign BCD  = bcd_q;
  assign OVF  = ovf_q;
`ifdef BCD_BLANK_EN
  assign BLANK = blank_q;
`endif

endmodule

// File: tb/tb_div_bcd_converter.sv
// Directed bench: a 2-digit and a 1-digit converter run in lockstep on the same requests.
module tb_div_bcd_converter;

  logic       CLK;
  logic       RST_N;
  logic       START;
  logic [4:0] BIN;
  logic       BUSY0, DONE0, OVF0;
  logic [7:0] BCD0;
  logic       BUSY1, DONE1, OVF1;
  logic [3:0] BCD1;
`ifdef BCD_BLANK_EN
  logic [1:0] BLANK0;
  logic [0:0] BLANK1;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int seen  = 0;

  div_bcd_converter #(.WIDTH(5), .DIGITS(2)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .START(START), .BIN(BIN),
    .BUSY(BUSY0), .DONE(DONE0), .BCD(BCD0), .OVF(OVF0)
`ifdef BCD_BLANK_EN
    , .BLANK(BLANK0)
`endif
  );

  div_bcd_converter #(.WIDTH(5), .DIGITS(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .START(START), .BIN(BIN),
    .BUSY(BUSY1), .DONE(DONE1), .BCD(BCD1), .OVF(OVF1)
`ifdef BCD_BLANK_EN
    , .BLANK(BLANK1)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic start_conv(input logic [4:0] b);
    BIN   = b;
    START = 1'b1;
    cyc   = 0;
    step();
    START = 1'b0;
  endtask

  task automatic finish_conv(input string tag, input logic [7:0] e0, input logic o0,
                             input logic [3:0] e1, input logic o1, input logic [1:0] eb0);
    while (DONE0 !== 1'b1 && cyc < 20) begin
      check({tag, "_busy"}, 32'(BUSY0), 32'd1);
      step();
    end
    check({tag, "_done"}, 32'(DONE0), 32'd1);
    check({tag, "_done1"}, 32'(DONE1), 32'd1);
    check({tag, "_lat"}, 32'(cyc), 32'd6);
    check({tag, "_busy_at_done"}, 32'(BUSY0), 32'd0);
    check({tag, "_bcd"}, 32'(BCD0), 32'(e0));
    check({tag, "_ovf"}, 32'(OVF0), 32'(o0));
    check({tag, "_bcd1"}, 32'(BCD1), 32'(e1));
    check({tag, "_ovf1"}, 32'(OVF1), 32'(o1));
`ifdef BCD_BLANK_EN
    check({tag, "_blank"}, 32'(BLANK0), 32'(eb0));
    check({tag, "_blank1"}, 32'(BLANK1), 32'd0);
`else
    if (eb0 === 2'bxx) check({tag, "_blank_arg"}, 32'(eb0), 32'd0);
`endif
    step();
    check({tag, "_done_pulse"}, 32'(DONE0), 32'd0);
    check({tag, "_bcd_hold"}, 32'(BCD0), 32'(e0));
  endtask

  initial begin
    RST_N = 1'b0;
    START = 1'b0;
    BIN   = 5'd0;
    #1;
    check("rst_busy", 32'(BUSY0), 32'd0);
    check("rst_done", 32'(DONE0), 32'd0);
    check("rst_bcd", 32'(BCD0), 32'd0);
    check("rst_ovf", 32'(OVF0), 32'd0);
    step();
    step();
    RST_N = 1'b1;
    step();

    start_conv(5'd31);
    finish_conv("b31", 8'h31, 1'b0, 4'h1, 1'b1, 2'b00);
    start_conv(5'd0);
    finish_conv("b0", 8'h00, 1'b0, 4'h0, 1'b0, 2'b10);
    start_conv(5'd10);
    finish_conv("b10", 8'h10, 1'b0, 4'h0, 1'b1, 2'b00);
    start_conv(5'd9);
    finish_conv("b9", 8'h09, 1'b0, 4'h9, 1'b0, 2'b10);
    start_conv(5'd13);
    finish_conv("b13", 8'h13, 1'b0, 4'h3, 1'b1, 2'b00);
    start_conv(5'd7);
    finish_conv("b7", 8'h07, 1'b0, 4'h7, 1'b0, 2'b10);
    start_conv(5'd20);
    finish_conv("b20", 8'h20, 1'b0, 4'h0, 1'b1, 2'b00);

    // Second request during cycle 3 of a conversion must be dropped.
    start_conv(5'd25);
    step();
    step();
    BIN   = 5'd7;
    START = 1'b1;
    step();
    START = 1'b0;
    finish_conv("b25_busy_start", 8'h25, 1'b0, 4'h5, 1'b1, 2'b00);
    seen = 0;
    repeat (10) begin
      if (DONE0 === 1'b1) seen++;
      step();
    end
    check("no_extra_done", 32'(seen), 32'd0);
    check("idle_after_drop", 32'(BUSY0), 32'd0);

    // Asynchronous reset in the middle of a BIN=19 conversion.
    start_conv(5'd19);
    step();
    check("mid_busy", 32'(BUSY0), 32'd1);
    #2;
    RST_N = 1'b0;
    #1;
    check("arst_busy", 32'(BUSY0), 32'd0);
    check("arst_done", 32'(DONE0), 32'd0);
    check("arst_bcd", 32'(BCD0), 32'd0);
    check("arst_ovf", 32'(OVF0), 32'd0);
    check("arst_ovf1", 32'(OVF1), 32'd0);
    step();
    RST_N = 1'b1;
    seen = 0;
    repeat (10) begin
      if (DONE0 === 1'b1 || BUSY0 === 1'b1) seen++;
      step();
    end
    check("no_done_after_rst", 32'(seen), 32'd0);
    start_conv(5'd4);
    finish_conv("b4", 8'h04, 1'b0, 4'h4, 1'b0, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
